sync_to_4phase_bridge: RTL

//  Upstream feeder for the error-detecting latch stage controller. Accepts

---
 rtl/sync_to_4phase_bridge.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sync_to_4phase_bridge.sv
// Valid/ready FIFO feeding a 4-phase bundled-data request/acknowledge port.
// Lack is synchronised before use; a stalled handshake raises a sticky error.
module sync_to_4phase_bridge #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         Ldata,
    output logic                     Lreq,
    input  logic                     Lack,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [SW-1:0] SETUP_LD = SW'(SETUP_CYCLES);
    localparam logic [WW-1:0] WMAX     = WW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACK_HI, ACK_LO} state_t;

    state_t                 state, state_nx;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [SYNC_STAGES-1:0] sync;
    logic                   lack_s;
    logic                   push, pop, waiting;
    logic [SW-1:0]          scnt, scnt_nx;
    logic [WW-1:0]          wcnt, wcnt_nx;
    logic                   lreq_nx, err_nx;

    // No bypass: a full FIFO refuses input even when a pop happens the same cycle.
    assign in_ready = !reset && (count < FULL);
    assign push     = in_valid && in_ready;
    assign lack_s   = sync[SYNC_STAGES-1];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], Lack};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset)    Ldata <= '0;
        else if (pop) Ldata <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            scnt        <= '0;
            wcnt        <= '0;
            Lreq        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            scnt        <= scnt_nx;
            wcnt        <= wcnt_nx;
            Lreq        <= lreq_nx;
            timeout_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        waiting  = 1'b0;
        scnt_nx  = scnt;
        wcnt_nx  = wcnt;
        lreq_nx  = Lreq;
        err_nx   = timeout_err;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    scnt_nx  = SETUP_LD;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (scnt != '0) begin
                    scnt_nx = scnt - 1'b1;
                end else if (!lack_s) begin
                    lreq_nx  = 1'b1;
                    wcnt_nx  = '0;
                    state_nx = ACK_HI;
                end
            end
            ACK_HI: begin
                if (lack_s) begin
                    lreq_nx  = 1'b0;
                    wcnt_nx  = '0;
                    state_nx = ACK_LO;
                end else begin
                    waiting = 1'b1;
                end
            end
            ACK_LO: begin
                if (!lack_s) state_nx = IDLE;
                else         waiting  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // Saturating wait counter; the flag is raised on the edge it reaches TIMEOUT.
        if (waiting && wcnt != WMAX) begin
            wcnt_nx = wcnt + 1'b1;
            if (wcnt_nx == WMAX) err_nx = 1'b1;
        end
    end

endmodule
